// File: rtl/bram_access_ctrl.sv
// Burst controller between a command/response stream and a single-port BRAM with op_done handshake.
// Optional macro BRAM_CTRL_TIMEOUT_EN adds an op_done watchdog that sets a sticky err flag.
module bram_access_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              wr_done,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_op_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic              write_q, write_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_last_q, rsp_last_d;
  logic              wr_done_q, wr_done_d;
  logic              timeout_hit;
  logic              last_beat;

  assign last_beat = (beat_q == len_q);

`ifdef BRAM_CTRL_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;

  // Counter restarts every time WAIT is entered, so it measures one access only.
  always_comb begin
    cnt_d = '0;
    if (state_q == WAIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == WAIT) && !mem_op_done && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg  = (TIMEOUT_CYC > 0);
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    len_d       = len_q;
    beat_d      = beat_q;
    write_d     = write_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    wr_done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          len_d   = cmd_len;
          write_d = cmd_write;
          beat_d  = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_op_done) begin
          if (write_q) begin
            if (last_beat) begin
              wr_done_d = 1'b1;
              state_d   = IDLE;
            end else begin
              addr_d  = addr_q + 1'b1;
              wdata_d = wdata_q + 1'b1;
              beat_d  = beat_q + 1'b1;
              state_d = ISSUE;
            end
          end else begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = mem_rdata;
            rsp_last_d  = last_beat;
            state_d     = RESP;
          end
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      RESP: begin
        // Response is frozen until accepted; the next beat is only issued afterwards.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + 1'b1;
            beat_d  = beat_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      write_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      write_q     <= write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      wr_done_q   <= wr_done_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign wr_done   = wr_done_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rd_en = (state_q == ISSUE) && !write_q;
  assign mem_wr_en = (state_q == ISSUE) && write_q;

endmodule

// File: tb/tb_bram_access_ctrl.sv
// Bench for bram_access_ctrl: BRAM model, expectation queues from burst arithmetic, per-cycle compare.
module tb_bram_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic [3:0] cmd_len;
  logic       rsp_valid, rsp_ready, rsp_last;
  logic [7:0] rsp_data;
  logic       wr_done, busy, err;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_wr_en, mem_rd_en, mem_op_done;

  always #5 clk = ~clk;

  bram_access_ctrl #(.ADDR_W(8), .DATA_W(8), .LEN_W(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .wr_done(wr_done), .busy(busy), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .mem_op_done(mem_op_done)
  );

  // BRAM: one-cycle registered read, op_done the cycle after an access (can be withheld).
  logic [7:0] mem [256];
  logic       pend, block_done, stray_done;

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (rst) pend <= 1'b0;
    else if (mem_wr_en || mem_rd_en) pend <= 1'b1;
    else if (mem_op_done) pend <= 1'b0;
  end
  assign mem_op_done = (pend & ~block_done) | stray_done;

  typedef struct {logic we; logic [7:0] addr; logic [7:0] wdata;} acc_t;
  typedef struct {logic [7:0] data; logic last;} rsp_t;

  acc_t       exp_acc[$];
  rsp_t       exp_rsp[$];
  int         exp_wr_done;
  logic [7:0] shadow [256];

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         busy_cnt = 0;
  int         wr_done_seen = 0;
  logic [7:0] acc_log_addr[$];
  int         acc_log_cyc[$];
  logic [7:0] rsp_log[$];
  logic       rsp_log_last[$];
  int         accept_log[$];
  logic       err_exp = 1'b0;
  logic       err_skip = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Per-cycle compare against the expectation queues.
  acc_t       cur_acc;
  rsp_t       cur_rsp;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  logic       prev_wr_done = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall   = 1'b0;
      prev_wr_done = 1'b0;
    end else begin
      cyc++;
      if (busy) busy_cnt++;
      chk("cmd_ready_vs_busy", cmd_ready, !busy);
      if (!err_skip) chk("err", err, err_exp);
      if (!rsp_valid) chk("last_without_valid", rsp_last, 1'b0);
      if (mem_rd_en || mem_wr_en) begin
        chk("one_enable", mem_rd_en & mem_wr_en, 1'b0);
        chk("no_access_while_rsp", rsp_valid, 1'b0);
        acc_log_addr.push_back(mem_addr);
        acc_log_cyc.push_back(cyc);
        chk("access_expected", exp_acc.size() != 0, 1'b1);
        if (exp_acc.size() != 0) begin
          cur_acc = exp_acc.pop_front();
          chk("acc_we", mem_wr_en, cur_acc.we);
          chk("acc_addr", mem_addr, cur_acc.addr);
          if (cur_acc.we) chk("acc_wdata", mem_wdata, cur_acc.wdata);
        end
      end
      if (rsp_valid) begin
        if (prev_stall) begin
          chk("stall_data_stable", rsp_data, prev_data);
          chk("stall_last_stable", rsp_last, prev_last);
        end
        chk("rsp_expected", exp_rsp.size() != 0, 1'b1);
        if (exp_rsp.size() != 0) begin
          cur_rsp = exp_rsp[0];
          chk("rsp_data", rsp_data, cur_rsp.data);
          chk("rsp_last", rsp_last, cur_rsp.last);
          if (rsp_ready) void'(exp_rsp.pop_front());
        end
        if (rsp_ready) begin
          rsp_log.push_back(rsp_data);
          rsp_log_last.push_back(rsp_last);
          accept_log.push_back(cyc);
        end
        prev_stall = !rsp_ready;
        prev_data  = rsp_data;
        prev_last  = rsp_last;
      end else begin
        prev_stall = 1'b0;
      end
      if (wr_done) begin
        wr_done_seen++;
        chk("wr_done_one_cycle", prev_wr_done, 1'b0);
        chk("wr_done_expected", exp_wr_done > 0, 1'b1);
        if (exp_wr_done > 0) exp_wr_done--;
      end
      prev_wr_done = wr_done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_log_addr.delete();
    acc_log_cyc.delete();
    rsp_log.delete();
    rsp_log_last.delete();
    accept_log.delete();
    busy_cnt = 0;
    wr_done_seen = 0;
  endtask

  // Queues the expected burst from address/seed arithmetic, then performs the handshake.
  task automatic send(input logic we, input logic [7:0] addr, input logic [7:0] seed,
                      input logic [3:0] len);
    int   n;
    acc_t a;
    rsp_t r;
    n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    chk("cmd_ready_before_send", cmd_ready, 1'b1);
    for (int i = 0; i <= int'(len); i++) begin
      a.we    = we;
      a.addr  = addr + 8'(i);
      a.wdata = seed + 8'(i);
      exp_acc.push_back(a);
      if (we) begin
        shadow[a.addr] = a.wdata;
      end else begin
        r.data = shadow[a.addr];
        r.last = (i == int'(len));
        exp_rsp.push_back(r);
      end
    end
    if (we) exp_wr_done++;
    cmd_valid = 1'b1;
    cmd_write = we;
    cmd_addr  = addr;
    cmd_wdata = seed;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
    cmd_write = ~we;
    cmd_addr  = ~addr;
    cmd_wdata = ~seed;
    cmd_len   = ~len;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_acc.size() != 0 || exp_rsp.size() != 0) && n < 500) begin
      tick();
      n++;
    end
    chk("burst_done_in_budget", n < 500, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 8'(i);
      shadow[i] = 8'(i);
    end
    mem[8'h0A]    = 8'hA5;
    shadow[8'h0A] = 8'hA5;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_len = '0;
    rsp_ready = 1'b1; block_done = 1'b0; stray_done = 1'b0; exp_wr_done = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_rsp_last", rsp_last, 1'b0);
    chk("rst_wr_done", wr_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_mem_wr_en", mem_wr_en, 1'b0);
    chk("rst_mem_rd_en", mem_rd_en, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    tick();
    rst = 1'b0;

    // Single read of the preloaded 0xA5 word with exact latency.
    clear_logs();
    send(1'b0, 8'h0A, 8'h00, 4'd0);
    @(negedge clk);
    chk("t1_rd_en", mem_rd_en, 1'b1);
    chk("t1_addr", mem_addr, 8'h0A);
    @(negedge clk);
    chk("t2_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    chk("t3_rsp_valid", rsp_valid, 1'b1);
    chk("t3_rsp_data", rsp_data, 8'hA5);
    chk("t3_rsp_last", rsp_last, 1'b1);
    wait_idle();

    // Address wrap across 0xFF and 3N-cycle burst duration.
    clear_logs();
    send(1'b0, 8'hFE, 8'h00, 4'd2);
    wait_idle();
    chk("wrap_busy_cycles", busy_cnt, 9);
    chk("wrap_acc_count", acc_log_addr.size(), 3);
    chk("wrap_rsp_count", rsp_log.size(), 3);
    if (acc_log_addr.size() == 3 && rsp_log.size() == 3) begin
      chk("wrap_addr0", acc_log_addr[0], 8'hFE);
      chk("wrap_addr1", acc_log_addr[1], 8'hFF);
      chk("wrap_addr2", acc_log_addr[2], 8'h00);
      chk("wrap_data0", rsp_log[0], 8'hFE);
      chk("wrap_data1", rsp_log[1], 8'hFF);
      chk("wrap_data2", rsp_log[2], 8'h00);
      chk("wrap_last", {rsp_log_last[0], rsp_log_last[1], rsp_log_last[2]}, 3'b001);
    end

    // Write-fill then read back.
    clear_logs();
    send(1'b1, 8'h20, 8'h10, 4'd3);
    wait_idle();
    tick();
    chk("fill_wr_done_count", wr_done_seen, 1);
    clear_logs();
    send(1'b0, 8'h20, 8'h00, 4'd3);
    wait_idle();
    chk("fill_rsp_count", rsp_log.size(), 4);
    if (rsp_log.size() == 4) begin
      chk("fill_rd", {rsp_log[0], rsp_log[1], rsp_log[2], rsp_log[3]}, 32'h10111213);
    end

    // Back-pressure with a stray op_done during the stall.
    clear_logs();
    rsp_ready = 1'b0;
    send(1'b0, 8'h30, 8'h00, 4'd1);
    for (int n = 0; n < 20 && !rsp_valid; n++) tick();
    chk("stall_rsp_valid", rsp_valid, 1'b1);
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    repeat (4) tick();
    chk("stall_acc_count", acc_log_addr.size(), 1);
    rsp_ready = 1'b1;
    wait_idle();
    chk("stall_rsp_count", rsp_log.size(), 2);
    if (rsp_log.size() == 2 && acc_log_cyc.size() == 2) begin
      chk("stall_rsp", {rsp_log[0], rsp_log[1]}, 16'h3031);
      chk("stall_reissue_gap", acc_log_cyc[1] - accept_log[0], 1);
    end
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    chk("stray_idle_busy", busy, 1'b0);

`ifdef BRAM_CTRL_TIMEOUT_EN
    // Watchdog: 16 WAIT cycles without op_done abandon the burst.
    err_skip = 1'b1;
    block_done = 1'b1;
    send(1'b0, 8'h05, 8'h00, 4'd0);
    repeat (17) @(negedge clk);
    chk("tmo_err_before", err, 1'b0);
    chk("tmo_busy_before", busy, 1'b1);
    @(negedge clk);
    chk("tmo_err", err, 1'b1);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_rsp_valid", rsp_valid, 1'b0);
    exp_rsp.delete();
    tick();
    block_done = 1'b0;
    send(1'b0, 8'h06, 8'h00, 4'd0);
    wait_idle();
    chk("tmo_err_sticky", err, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("tmo_err_cleared", err, 1'b0);
    err_skip = 1'b0;
`else
    // Without the watchdog WAIT holds until op_done finally arrives.
    block_done = 1'b1;
    send(1'b0, 8'h05, 8'h00, 4'd0);
    repeat (20) tick();
    chk("hold_busy", busy, 1'b1);
    chk("hold_rsp_valid", rsp_valid, 1'b0);
    chk("hold_err", err, 1'b0);
    block_done = 1'b0;
    wait_idle();
`endif

    // Reset during WAIT of the second beat of a 4-beat write.
    clear_logs();
    send(1'b1, 8'h40, 8'h77, 4'd3);
    for (int n = 0; n < 50 && acc_log_addr.size() < 2; n++) tick();
    chk("rst_mid_two_beats", acc_log_addr.size(), 2);
    rst = 1'b1;
    exp_acc.delete();
    exp_wr_done = 0;
    tick();
    rst = 1'b0;
    chk("rst_mid_cmd_ready", cmd_ready, 1'b1);
    chk("rst_mid_busy", busy, 1'b0);
    repeat (10) tick();
    chk("rst_mid_no_more_acc", acc_log_addr.size(), 2);
    chk("rst_mid_no_wr_done", wr_done_seen, 0);

    chk("end_acc_queue_empty", exp_acc.size(), 0);
    chk("end_rsp_queue_empty", exp_rsp.size(), 0);
    chk("end_wr_done_pending", exp_wr_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_access_ctrl.md
BRAM_ACCESS_CTRL -- requirements
Module: bram_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have parameter LEN_W, default 4, burst length field width.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 16, op_done wait limit in cycles.
REQ-005 SHALL have ports, one clock, reset synchronous and active-high:
  clk  in  1  system clock, all logic on rising edge
  rst  in  1  synchronous active-high reset
  cmd_valid  in  1  command offered
  cmd_ready  out  1  controller can accept command
  cmd_write  in  1  1 = write-fill burst, 0 = read burst
  cmd_addr  in  ADDR_W  burst start address
  cmd_wdata  in  DATA_W  write-fill seed value
  cmd_len  in  LEN_W  beats minus one (0 = single beat)
  rsp_valid  out  1  read data available
  rsp_ready  in  1  consumer accepts read data
  rsp_data  out  DATA_W  read data
  rsp_last  out  1  final beat of read burst
  wr_done  out  1  one-cycle pulse, write burst complete
  busy  out  1  high whenever state is not IDLE
  err  out  1  sticky timeout flag
  mem_addr  out  ADDR_W  to BRAM address
  mem_wdata  out  DATA_W  to BRAM data_in
  mem_wr_en  out  1  to BRAM write enable
  mem_rd_en  out  1  to BRAM read enable
  mem_rdata  in  DATA_W  from BRAM data_out
  mem_op_done  in  1  from BRAM op_done

Function
REQ-006 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-007 SHALL drive cmd_ready high only in IDLE; handshake = cmd_valid & cmd_ready at a rising edge.
REQ-008 On handshake SHALL latch addr, seed, len, write into internal registers and enter ISSUE; cmd_* changes afterwards are ignored.
REQ-009 In ISSUE SHALL assert exactly one of mem_wr_en/mem_rd_en for exactly one cycle, mem_addr = current address, then enter WAIT.
REQ-010 Write beat i SHALL use mem_wdata = (seed + i) mod 2^DATA_W.
REQ-011 In WAIT, on mem_op_done for a read SHALL capture mem_rdata into rsp_data, set rsp_valid, and enter RESP.
REQ-012 rsp_last SHALL be high with rsp_valid only on beat cmd_len.
REQ-013 In RESP SHALL hold rsp_valid, rsp_data, rsp_last stable until rsp_ready; no new BRAM access while rsp_valid is high.
REQ-014 On rsp_valid & rsp_ready SHALL drop rsp_valid; if beats remain, increment address and enter ISSUE, else enter IDLE.
REQ-015 In WAIT, on mem_op_done for a write SHALL increment address and enter ISSUE if beats remain, else pulse wr_done one cycle and enter IDLE.
REQ-016 Address increment SHALL wrap modulo 2^ADDR_W (0xFF -> 0x00 at default).
REQ-017 Read latency: handshake at edge T -> mem_rd_en high in cycle T+1 -> rsp_valid high from cycle T+3 (BRAM 1-cycle registered read).
REQ-018 Burst of N beats with rsp_ready held high SHALL complete in 3N cycles.
REQ-019 mem_op_done outside WAIT SHALL be ignored.

Reset
REQ-020 While rst is high at a rising edge SHALL enter IDLE, clear all internal registers, and drive cmd_ready=1 from the following cycle.
REQ-021 Reset values: rsp_valid=0, rsp_data=0, rsp_last=0, wr_done=0, busy=0, err=0, mem_addr=0, mem_wdata=0, mem_wr_en=0, mem_rd_en=0.
REQ-022 Reset mid-burst SHALL abandon the burst with no further BRAM access and no rsp_valid or wr_done.

Configuration
REQ-023 Macro BRAM_CTRL_TIMEOUT_EN defined: cycle counter runs in WAIT; if mem_op_done absent for TIMEOUT_CYC cycles, SHALL set err, abandon burst, enter IDLE with no rsp_valid or wr_done; err clears only on rst.
REQ-024 Macro undefined: no counter; WAIT holds indefinitely; err tied to 0.

Verification
REQ-025 Read addr 0x0A len 0 on freshly initialised BRAM -> one rsp beat 0xA5, rsp_last=1, rsp_valid at T+3.
REQ-026 Read addr 0xFE len 2 -> mem_addr sequence 0xFE, 0xFF, 0x00; rsp_data 0xFE, 0xFF, 0x00; rsp_last on third beat only.
REQ-027 Write addr 0x20 seed 0x10 len 3, then read addr 0x20 len 3 -> one wr_done pulse; reads return 0x10, 0x11, 0x12, 0x13.
REQ-028 Read len 1 with rsp_ready low 5 cycles on beat 0 -> rsp_data stable, no mem_rd_en during stall, second access issues only after acceptance.
REQ-029 rst asserted in WAIT of beat 2 of 4-beat write -> IDLE, cmd_ready=1 next cycle, no wr_done, no further mem_wr_en.
REQ-030 With BRAM_CTRL_TIMEOUT_EN, mem_op_done forced 0 -> err=1 after 16 WAIT cycles, busy=0, err holds until rst.
